ins_fetch_seq: RTL and testbench

- Program-counter owner and instruction-fetch sequencer for the RV32I core.
- Consumes PC-write requests from the branch/jump execute units (reg_pc_w_op / reg_pc_w_val) and drives a request/acknowledge memory read port.
- Presents each fetched instruction with its PC to decode over a valid/accept handshake.
- Discards stale fetches when a redirect arrives mid-transaction.

---
 rtl/rv32_core_pkg.sv | 23 ++
 rtl/ins_fetch_pc_reg.sv | 30 +++
 rtl/ins_fetch_seq.sv | 151 +++++++++++++++
 tb/tb_ins_fetch_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_core_pkg.sv
// Shared RV32 core constants: fetch state encoding, PC reset value,
// sequential increment and instruction alignment mask.
package rv32_core_pkg;

    localparam logic [2:0] FS_IDLE  = 3'd0;
    localparam logic [2:0] FS_REQ   = 3'd1;
    localparam logic [2:0] FS_HOLD  = 3'd2;
    localparam logic [2:0] FS_DRAIN = 3'd3;
    localparam logic [2:0] FS_HALT  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = FS_IDLE,
        ST_REQ   = FS_REQ,
        ST_HOLD  = FS_HOLD,
        ST_DRAIN = FS_DRAIN,
        ST_HALT  = FS_HALT
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INS_BYTES        = 32'd4;
    localparam logic [31:0] ALIGN_MASK       = 32'h0000_0003;

endpackage

// File: rtl/ins_fetch_pc_reg.sv
// Architectural fetch PC register with reset > load > increment > hold
// priority, plus alignment check of the incoming redirect target.
module ins_fetch_pc_reg
    import rv32_core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en,
    input  logic [31:0] load_val,
    input  logic        inc_en,
    output logic [31:0] pc,
    output logic        target_misaligned
);

    assign target_misaligned = |(load_val & ALIGN_MASK);

    // Increment wraps naturally at 32 bits (0xFFFF_FFFC -> 0x0000_0000).
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load_en) begin
            pc <= load_val;
        end else if (inc_en) begin
            pc <= pc + INS_BYTES;
        end
    end

endmodule

// File: rtl/ins_fetch_seq.sv
// Instruction-fetch sequencer: owns the PC, issues req/ack memory reads and
// hands instructions to decode. Both handshakes complete on a cycle where
// the producer's strobe (mem_ack / ins_valid) and the consumer's side are high.
module ins_fetch_seq
    import rv32_core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_pc_w_op,
    input  logic [31:0] reg_pc_w_val,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        ins_valid,
    output logic [31:0] ins_data,
    output logic [31:0] ins_pc,
    input  logic        ins_accept,
    output logic [31:0] reg_pc_val,
    output logic        fetch_misalign,
    output logic [2:0]  fetch_state
);

    fetch_state_e state_q, state_d;
    logic         redirect_pending_q, redirect_pending_d;
    logic         halt_pending_q, halt_pending_d;
    logic [31:0]  req_addr_q;
    logic [31:0]  pc;
    logic         pc_load, pc_inc, target_misaligned;
    logic         redir_ok, redir_bad;
    logic         misalign_set, capture;

    ins_fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk               (clk),
        .rst               (rst),
        .load_en           (pc_load),
        .load_val          (reg_pc_w_val),
        .inc_en            (pc_inc),
        .pc                (pc),
        .target_misaligned (target_misaligned)
    );

    assign redir_ok  = reg_pc_w_op && !target_misaligned;
    assign redir_bad = reg_pc_w_op && target_misaligned;

    always_comb begin
        state_d            = state_q;
        redirect_pending_d = redirect_pending_q;
        halt_pending_d     = halt_pending_q;
        pc_load            = 1'b0;
        pc_inc             = 1'b0;
        misalign_set       = 1'b0;
        capture            = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (redir_bad) begin
                    misalign_set = 1'b1;
                    state_d      = ST_HALT;
                end else begin
                    pc_load = redir_ok;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (redir_bad) begin
                    // An unacked request must still be drained before halting.
                    misalign_set       = 1'b1;
                    redirect_pending_d = !mem_ack;
                    halt_pending_d     = !mem_ack;
                    state_d            = mem_ack ? ST_HALT : ST_DRAIN;
                end else if (redir_ok) begin
                    pc_load = 1'b1;
                    if (!mem_ack) begin
                        redirect_pending_d = 1'b1;
                        state_d            = ST_DRAIN;
                    end
                end else if (mem_ack) begin
                    capture = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                if (redir_bad) begin
                    misalign_set   = 1'b1;
                    halt_pending_d = 1'b1;
                end else if (redir_ok) begin
                    pc_load = 1'b1;
                end
                if (mem_ack) begin
                    redirect_pending_d = 1'b0;
                    halt_pending_d     = 1'b0;
                    state_d            = (halt_pending_q || redir_bad) ? ST_HALT : ST_REQ;
                end
            end
            ST_HOLD: begin
                if (redir_bad) begin
                    misalign_set = 1'b1;
                    state_d      = ST_HALT;
                end else if (redir_ok) begin
                    pc_load = 1'b1;
                    state_d = ST_REQ;
                end else if (ins_accept) begin
                    pc_inc  = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= ST_IDLE;
            redirect_pending_q <= 1'b0;
            halt_pending_q     <= 1'b0;
            req_addr_q         <= RESET_PC;
            ins_data           <= 32'h0;
            ins_pc             <= 32'h0;
            fetch_misalign     <= 1'b0;
        end else begin
            state_q            <= state_d;
            redirect_pending_q <= redirect_pending_d;
            halt_pending_q     <= halt_pending_d;
            // Remember the in-flight address so DRAIN can keep presenting it.
            if (state_q == ST_REQ) begin
                req_addr_q <= pc;
            end
            if (capture) begin
                ins_data <= mem_rdata;
                ins_pc   <= pc;
            end
            if (misalign_set) begin
                fetch_misalign <= 1'b1;
            end
        end
    end

    assign mem_req     = (state_q == ST_REQ) || (state_q == ST_DRAIN);
    assign mem_addr    = redirect_pending_q ? req_addr_q : pc;
    assign ins_valid   = (state_q == ST_HOLD);
    assign reg_pc_val  = pc;
    assign fetch_state = state_q;

endmodule

// File: tb/tb_ins_fetch_seq.sv
// Directed bench for ins_fetch_seq: sequential fetch, backpressure, redirects
// in every busy state, wrap-around, misaligned halt and recovery via reset.
module tb_ins_fetch_seq;
    import rv32_core_pkg::*;

    logic        clk;
    logic        rst;
    logic        reg_pc_w_op;
    logic [31:0] reg_pc_w_val;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        ins_valid;
    logic [31:0] ins_data;
    logic [31:0] ins_pc;
    logic        ins_accept;
    logic [31:0] reg_pc_val;
    logic        fetch_misalign;
    logic [2:0]  fetch_state;

    int checks;
    int errors;

    ins_fetch_seq dut (
        .clk            (clk),
        .rst            (rst),
        .reg_pc_w_op    (reg_pc_w_op),
        .reg_pc_w_val   (reg_pc_w_val),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .ins_valid      (ins_valid),
        .ins_data       (ins_data),
        .ins_pc         (ins_pc),
        .ins_accept     (ins_accept),
        .reg_pc_val     (reg_pc_val),
        .fetch_misalign (fetch_misalign),
        .fetch_state    (fetch_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Entered in REQ at addr; memory acks one cycle late; ends in HOLD.
    task automatic fetch_word(input string tag, input logic [31:0] addr, input logic [31:0] data);
        check1({tag, "_req"}, mem_req, 1'b1);
        check32({tag, "_addr"}, mem_addr, addr);
        tick();
        check32({tag, "_addr_hold"}, mem_addr, addr);
        check1({tag, "_nvalid"}, ins_valid, 1'b0);
        mem_ack   = 1'b1;
        mem_rdata = data;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        check1({tag, "_valid"}, ins_valid, 1'b1);
        check32({tag, "_data"}, ins_data, data);
        check32({tag, "_pc"}, ins_pc, addr);
        check1({tag, "_req_off"}, mem_req, 1'b0);
    endtask

    task automatic accept_word(input string tag, input logic [31:0] next_addr);
        ins_accept = 1'b1;
        tick();
        ins_accept = 1'b0;
        check1({tag, "_valid_drop"}, ins_valid, 1'b0);
        check1({tag, "_next_req"}, mem_req, 1'b1);
        check32({tag, "_next_addr"}, mem_addr, next_addr);
        check32({tag, "_next_pc"}, reg_pc_val, next_addr);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        reg_pc_w_op  = 1'b0;
        reg_pc_w_val = 32'h0;
        mem_ack      = 1'b0;
        mem_rdata    = 32'h0;
        ins_accept   = 1'b0;
        tick();
        tick();

        check1("rst_req", mem_req, 1'b0);
        check32("rst_addr", mem_addr, 32'h0);
        check1("rst_valid", ins_valid, 1'b0);
        check32("rst_data", ins_data, 32'h0);
        check32("rst_ins_pc", ins_pc, 32'h0);
        check1("rst_misalign", fetch_misalign, 1'b0);
        check32("rst_pc", reg_pc_val, 32'h0);
        check32("rst_state", {29'b0, fetch_state}, {29'b0, FS_IDLE});

        rst = 1'b0;
        tick();
        check32("idle_to_req", {29'b0, fetch_state}, {29'b0, FS_REQ});

        fetch_word("seq0", 32'h0, 32'h0000_0013);
        accept_word("seq0", 32'h4);

        fetch_word("seq1", 32'h4, 32'h0000_0013);
        for (int i = 0; i < 5; i++) begin
            tick();
            check1("bp_valid", ins_valid, 1'b1);
            check32("bp_data", ins_data, 32'h0000_0013);
            check32("bp_ins_pc", ins_pc, 32'h4);
            check1("bp_req", mem_req, 1'b0);
            check32("bp_pc", reg_pc_val, 32'h4);
        end
        accept_word("seq1", 32'h8);

        // Ack withheld three cycles at 0x8 while a redirect to 0x200 arrives.
        tick();
        check32("mid_addr0", mem_addr, 32'h8);
        reg_pc_w_op  = 1'b1;
        reg_pc_w_val = 32'h200;
        tick();
        reg_pc_w_op  = 1'b0;
        check32("mid_state", {29'b0, fetch_state}, {29'b0, FS_DRAIN});
        check1("mid_req", mem_req, 1'b1);
        check32("mid_addr1", mem_addr, 32'h8);
        check32("mid_pc", reg_pc_val, 32'h200);
        tick();
        check32("mid_addr2", mem_addr, 32'h8);
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_0BAD;
        tick();
        mem_ack   = 1'b0;
        check1("mid_no_valid", ins_valid, 1'b0);
        check32("mid_no_data", ins_data, 32'h0000_0013);
        fetch_word("tgt200", 32'h200, 32'h0000_0513);

        // Redirect together with accept: target wins over PC+4.
        reg_pc_w_op  = 1'b1;
        reg_pc_w_val = 32'h100;
        ins_accept   = 1'b1;
        tick();
        reg_pc_w_op  = 1'b0;
        ins_accept   = 1'b0;
        check1("hold_redir_valid", ins_valid, 1'b0);
        check32("hold_redir_addr", mem_addr, 32'h100);
        check32("hold_redir_pc", reg_pc_val, 32'h100);
        fetch_word("tgt100", 32'h100, 32'h0000_0593);

        reg_pc_w_op  = 1'b1;
        reg_pc_w_val = 32'hFFFF_FFFC;
        tick();
        reg_pc_w_op  = 1'b0;
        fetch_word("wrap", 32'hFFFF_FFFC, 32'h0000_0613);
        accept_word("wrap", 32'h0);

        // Redirect and ack in the same REQ cycle: data dropped, stay in REQ.
        reg_pc_w_op  = 1'b1;
        reg_pc_w_val = 32'h300;
        mem_ack      = 1'b1;
        mem_rdata    = 32'hBAD1_BAD1;
        tick();
        reg_pc_w_op  = 1'b0;
        mem_ack      = 1'b0;
        check1("same_valid", ins_valid, 1'b0);
        check32("same_state", {29'b0, fetch_state}, {29'b0, FS_REQ});
        check32("same_addr", mem_addr, 32'h300);
        check32("same_data", ins_data, 32'h0000_0613);

        // Misaligned target while a request is outstanding: drain, then halt.
        reg_pc_w_op  = 1'b1;
        reg_pc_w_val = 32'h202;
        tick();
        reg_pc_w_op  = 1'b0;
        check1("mis_flag", fetch_misalign, 1'b1);
        check1("mis_drain_req", mem_req, 1'b1);
        check32("mis_drain_addr", mem_addr, 32'h300);
        check32("mis_pc", reg_pc_val, 32'h300);
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD2_BAD2;
        tick();
        check32("halt_state", {29'b0, fetch_state}, {29'b0, FS_HALT});
        reg_pc_w_op  = 1'b1;
        reg_pc_w_val = 32'h400;
        ins_accept   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check1("halt_req", mem_req, 1'b0);
            check1("halt_valid", ins_valid, 1'b0);
            check1("halt_flag", fetch_misalign, 1'b1);
            check32("halt_pc", reg_pc_val, 32'h300);
        end
        reg_pc_w_op = 1'b0;
        ins_accept  = 1'b0;
        mem_ack     = 1'b0;

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check1("rerst_flag", fetch_misalign, 1'b0);
        check32("rerst_pc", reg_pc_val, 32'h0);
        check32("rerst_state", {29'b0, fetch_state}, {29'b0, FS_IDLE});

        // Redirect while IDLE loads the PC before the first request.
        reg_pc_w_op  = 1'b1;
        reg_pc_w_val = 32'h40;
        tick();
        reg_pc_w_op  = 1'b0;
        fetch_word("idle_redir", 32'h40, 32'h0000_0693);
        accept_word("idle_redir", 32'h44);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
